// File: rtl/alu_sequencer.sv
// alu_sequencer
// Multi-cycle controller around a 4-entry register file and an N-bit ALU.
// Each instruction walks IDLE -> READ -> EXEC -> WB -> IDLE, so the block
// completes one instruction every four cycles.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   instr_valid       instruction fields valid
//   instr_ready       sequencer is in IDLE and can accept an instruction
//   opcode, rd, rs,   instruction fields; they are sampled only on the
//   rt, imm           accept edge
//   busy              high in READ, EXEC and WB
//   done              one-cycle pulse while in WB
//   result, carry,    result of the last completed instruction, held
//   zero              until the next WB
//   dbg_addr/dbg_data combinational debug read port of the register file
module alu_sequencer #(
    parameter int Nsize = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       opcode,
    input  logic [1:0]       rd,
    input  logic [1:0]       rs,
    input  logic [1:0]       rt,
    input  logic [Nsize-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [Nsize-1:0] result,
    output logic             carry,
    output logic             zero,
    input  logic [1:0]       dbg_addr,
    output logic [Nsize-1:0] dbg_data
);

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_LI  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;

    logic [2:0]       op_r;
    logic [1:0]       rd_r;
    logic [1:0]       rs_r;
    logic [1:0]       rt_r;
    logic [Nsize-1:0] imm_r;
    logic [Nsize-1:0] a_r;
    logic [Nsize-1:0] b_r;
    logic [Nsize-1:0] result_r;
    logic             carry_r;
    logic             zero_r;
    logic [Nsize-1:0] regs_r [0:3];
    logic [Nsize:0]   alu_s;

    // ALU slice: returns {carry, result}. Carry is only meaningful for ADD
    // and SUB; SUB carry=1 means no borrow.
    function automatic logic [Nsize:0] alu_calc(
        input logic [2:0]       op,
        input logic [Nsize-1:0] a,
        input logic [Nsize-1:0] b
    );
        logic [Nsize:0]   wide;
        logic [Nsize-1:0] diff;
        logic             ovf;
        logic             lt;
        wide = {(Nsize+1){1'b0}};
        diff = a - b;
        // Signed overflow of a-b: operands differ in sign and the
        // difference takes the sign of b.
        ovf  = (a[Nsize-1] ^ b[Nsize-1]) & (diff[Nsize-1] ^ a[Nsize-1]);
        lt   = diff[Nsize-1] ^ ovf;
        case (op)
            OP_MOV:  wide = {1'b0, a};
            OP_NOT:  wide = {1'b0, ~a};
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} + {1'b0, ~b} + {{Nsize{1'b0}}, 1'b1};
            OP_OR:   wide = {1'b0, a | b};
            OP_AND:  wide = {1'b0, a & b};
            OP_SLT:  wide = {{Nsize{1'b0}}, lt};
            OP_LI:   wide = {1'b0, a};
            default: wide = {(Nsize+1){1'b0}};
        endcase
        return wide;
    endfunction

    assign alu_s       = alu_calc(op_r, a_r, b_r);
    assign instr_ready = (state_r == IDLE);
    assign busy        = (state_r != IDLE);
    assign done        = (state_r == WB);
    assign result      = result_r;
    assign carry       = carry_r;
    assign zero        = zero_r;
    assign dbg_data    = regs_r[dbg_addr];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: fixed four-step sequence, IDLE waits for valid.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (instr_valid) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ:    state_s = EXEC;
            EXEC:    state_s = WB;
            WB:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Instruction register, operand latches and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 3'b000;
            rd_r     <= 2'b00;
            rs_r     <= 2'b00;
            rt_r     <= 2'b00;
            imm_r    <= {Nsize{1'b0}};
            a_r      <= {Nsize{1'b0}};
            b_r      <= {Nsize{1'b0}};
            result_r <= {Nsize{1'b0}};
            carry_r  <= 1'b0;
            zero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_valid) begin
                        op_r  <= opcode;
                        rd_r  <= rd;
                        rs_r  <= rs;
                        rt_r  <= rt;
                        imm_r <= imm;
                    end
                end
                READ: begin
                    // Operands are read before the write-back of this
                    // instruction, so rd==rs/rt sees the old value.
                    a_r <= (op_r == OP_LI) ? imm_r : regs_r[rs_r];
                    b_r <= regs_r[rt_r];
                end
                EXEC: begin
                    // Loading here makes the outputs change on WB entry.
                    result_r <= alu_s[Nsize-1:0];
                    carry_r  <= alu_s[Nsize];
                    zero_r   <= (alu_s[Nsize-1:0] == {Nsize{1'b0}});
                end
                WB:      ;
                default: ;
            endcase
        end
    end

    // Register file: cleared on reset, written at the end of WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= {Nsize{1'b0}};
            end
        end else if (state_r == WB) begin
            regs_r[rd_r] <= result_r;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed sequence, a valid-held
// streaming run, a mid-instruction reset and a randomized run, all checked
// against an arithmetic reference model of the register file.
module tb_alu_sequencer;

    localparam int N = 8;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         instr_valid;
    logic         instr_ready;
    logic [2:0]   opcode;
    logic [1:0]   rd;
    logic [1:0]   rs;
    logic [1:0]   rt;
    logic [N-1:0] imm;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         carry;
    logic         zero;
    logic [1:0]   dbg_addr;
    logic [N-1:0] dbg_data;

    int checks   = 0;
    int failures = 0;
    int model_regs [4];

    alu_sequencer #(.Nsize(N)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .opcode(opcode), .rd(rd), .rs(rs),
        .rt(rt), .imm(imm), .busy(busy), .done(done), .result(result),
        .carry(carry), .zero(zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Reference semantics written directly from the instruction definitions.
    function automatic void model_exec(input int op, input int a, input int b,
                                       output int res, output int cy);
        int sa;
        int sb;
        cy = 0;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        case (op)
            0, 7: res = a;
            1: res = (M - 1) - a;
            2: begin res = (a + b) % M; cy = (a + b >= M) ? 1 : 0; end
            3: begin res = (a - b + M) % M; cy = (a >= b) ? 1 : 0; end
            4: res = a | b;
            5: res = a & b;
            6: res = (sa < sb) ? 1 : 0;
            default: res = 0;
        endcase
    endfunction

    task automatic scramble_fields();
        opcode = 3'($urandom);
        rd     = 2'($urandom);
        rs     = 2'($urandom);
        rt     = 2'($urandom);
        imm    = N'($urandom);
    endtask

    task automatic check_dbg(input string tag, input int addr, input int expected);
        dbg_addr = 2'(addr);
        #1;
        check_val(tag, dbg_data, expected);
    endtask

    // Issues one instruction from IDLE (called just after a negedge) and
    // checks the whole 4-cycle sequence. Returns just after a negedge in IDLE.
    task automatic run_instr(input int op, input int d, input int s, input int t, input int im);
        int a;
        int b;
        int res;
        int cy;
        a = (op == 7) ? im : model_regs[s];
        b = model_regs[t];
        model_exec(op, a, b, res, cy);
        check_val("ready_idle", instr_ready, 1);
        opcode = 3'(op); rd = 2'(d); rs = 2'(s); rt = 2'(t); imm = N'(im);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        scramble_fields();
        check_val("busy_read", busy, 1);
        check_val("ready_read", instr_ready, 0);
        check_val("done_read", done, 0);
        @(negedge clk);
        check_val("done_exec", done, 0);
        check_val("busy_exec", busy, 1);
        @(negedge clk);
        check_val("done_wb", done, 1);
        check_val("result", result, res);
        check_val("carry", carry, cy);
        check_val("zero", zero, (res == 0) ? 1 : 0);
        model_regs[d] = res;
        @(negedge clk);
        check_val("done_after", done, 0);
        check_val("ready_after", instr_ready, 1);
        check_val("result_hold", result, res);
        check_dbg("dbg_wb", d, res);
    endtask

    initial begin
        int res_e;
        int cy_e;
        int a;
        int op_i;
        int rd_i;
        int rs_i;
        int rt_i;
        int imm_i;

        rst = 1'b1; instr_valid = 1'b0; dbg_addr = 2'd0;
        opcode = 3'd0; rd = 2'd0; rs = 2'd0; rt = 2'd0; imm = '0;
        res_e = 0; cy_e = 0;
        for (int i = 0; i < 4; i++) model_regs[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_ready", instr_ready, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_result", result, 0);
        check_val("rst_carry", carry, 0);
        check_val("rst_zero", zero, 0);
        for (int i = 0; i < 4; i++) check_dbg("rst_reg", i, 0);

        // Directed sequence.
        run_instr(7, 1, 0, 0, 'h7F);
        run_instr(7, 2, 0, 0, 'h01);
        check_dbg("plan_r1", 1, 'h7F);
        run_instr(2, 3, 1, 2, 0);
        check_val("plan_add", result, 'h80);
        run_instr(2, 0, 3, 3, 0);
        check_val("plan_add_wrap_carry", carry, 1);
        run_instr(3, 0, 2, 1, 0);
        check_val("plan_sub", result, 'h82);
        run_instr(6, 0, 3, 1, 0);
        check_val("plan_slt_true", result, 1);
        run_instr(6, 0, 1, 3, 0);
        check_val("plan_slt_false_zero", zero, 1);
        run_instr(0, 1, 1, 2, 0);
        run_instr(1, 2, 2, 0, 0);
        check_dbg("plan_not_self", 2, 'hFE);
        check_dbg("plan_mov_self", 1, 'h7F);
        run_instr(7, 1, 0, 0, 'hF0);
        run_instr(7, 2, 0, 0, 'h3C);
        run_instr(4, 0, 1, 2, 0);
        check_val("plan_or", result, 'hFC);
        run_instr(5, 3, 1, 2, 0);
        check_val("plan_and", result, 'h30);

        // instr_valid held high; fields change while busy.
        instr_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k % 4 == 0) begin
                check_val("stream_ready", instr_ready, 1);
                check_val("stream_idle_done", done, 0);
                op_i = $urandom_range(0, 7); rd_i = $urandom_range(0, 3);
                rs_i = $urandom_range(0, 3); rt_i = $urandom_range(0, 3);
                imm_i = $urandom_range(0, M - 1);
                a = (op_i == 7) ? imm_i : model_regs[rs_i];
                model_exec(op_i, a, model_regs[rt_i], res_e, cy_e);
                model_regs[rd_i] = res_e;
                opcode = 3'(op_i); rd = 2'(rd_i); rs = 2'(rs_i);
                rt = 2'(rt_i); imm = N'(imm_i);
            end else begin
                check_val("stream_not_ready", instr_ready, 0);
                scramble_fields();
                if (k % 4 == 3) begin
                    check_val("stream_done", done, 1);
                    check_val("stream_result", result, res_e);
                    check_val("stream_carry", carry, cy_e);
                end
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) check_dbg("stream_reg", i, model_regs[i]);

        // Reset during EXEC of ADD r3,r1,r2 aborts without write-back.
        run_instr(7, 1, 0, 0, 'h25);
        check_val("pre_rst_ready", instr_ready, 1);
        opcode = 3'd2; rd = 2'd3; rs = 2'd1; rt = 2'd2; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        check_val("abort_in_exec", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_done", done, 0);
        check_val("abort_ready", instr_ready, 1);
        check_val("abort_busy", busy, 0);
        check_val("abort_result", result, 0);
        check_val("abort_carry", carry, 0);
        check_val("abort_zero", zero, 0);
        for (int i = 0; i < 4; i++) model_regs[i] = 0;
        for (int i = 0; i < 4; i++) check_dbg("abort_reg", i, 0);
        @(negedge clk);
        check_val("abort_no_late_done", done, 0);
        run_instr(7, 3, 0, 0, 'h5A);

        // Randomized instructions.
        for (int n = 0; n < 40; n++) begin
            run_instr($urandom_range(0, 7), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, M - 1));
        end
        for (int i = 0; i < 4; i++) check_dbg("final_reg", i, model_regs[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
